ps2_rx_controller: RTL and testbench

Sequences reception of PS/2 keyboard frames in the clock50 domain. Oversamples the asynchronous PS/2 clock and data lines and frames the 11-bit packets (start, 8 data LSB-first, odd parity, stop). Validates each frame, then decodes E0/F0 prefixes into make/break key events. Maintains a 3-deep history of make codes that feeds the hex display path in place of free-running shift registers.

---
 rtl/ps2_rx_controller.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_rx_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_controller.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, frames 11-bit packets,
// validates start/parity/stop and decodes E0/F0 prefixes into make/break events.
module ps2_rx_controller #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock50,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_make,
    output logic       key_break,
    output logic [7:0] key1,
    output logic [7:0] key2,
    output logic [7:0] key3,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK, DECODE} state_t;

    state_t      state_q, state_d;
    logic        clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [10:0] shreg_q, shreg_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic        held_q, held_d;
    logic [7:0]  held_code_q, held_code_d;
    logic [7:0]  byte_data_q, byte_data_d, key_code_q, key_code_d;
    logic [7:0]  key1_q, key1_d, key2_q, key2_d, key3_q, key3_d;
    logic        byte_valid_q, byte_valid_d, key_ext_q, key_ext_d;
    logic        key_make_q, key_make_d, key_break_q, key_break_d;
    logic        parity_err_q, parity_err_d, frame_err_q, frame_err_d;

    logic       fall, timeout_hit, stop_bad, parity_bad;
    logic [7:0] rx_byte;

    assign fall        = clk_prev_q & ~clk_s2_q;
    assign timeout_hit = (state_q == RECV) && !fall && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign stop_bad    = ~shreg_q[10];
    assign parity_bad  = ~(^shreg_q[9:1]);
    assign rx_byte     = shreg_q[8:1];

    // State register plus all datapath flops; sync flops reset high so no false edge.
    always_ff @(posedge clock50) begin
        if (!resetn) begin
            state_q      <= IDLE;
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            clk_prev_q   <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s2_q     <= 1'b1;
            bitcnt_q     <= '0;
            shreg_q      <= '0;
            tmo_q        <= '0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            held_q       <= 1'b0;
            held_code_q  <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            key_code_q   <= '0;
            key_ext_q    <= 1'b0;
            key_make_q   <= 1'b0;
            key_break_q  <= 1'b0;
            key1_q       <= '0;
            key2_q       <= '0;
            key3_q       <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_s1_q     <= ps2_clk;
            clk_s2_q     <= clk_s1_q;
            clk_prev_q   <= clk_s2_q;
            dat_s1_q     <= ps2_dat;
            dat_s2_q     <= dat_s1_q;
            bitcnt_q     <= bitcnt_d;
            shreg_q      <= shreg_d;
            tmo_q        <= tmo_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            held_q       <= held_d;
            held_code_q  <= held_code_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            key_code_q   <= key_code_d;
            key_ext_q    <= key_ext_d;
            key_make_q   <= key_make_d;
            key_break_q  <= key_break_d;
            key1_q       <= key1_d;
            key2_q       <= key2_d;
            key3_q       <= key3_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fall && !dat_s2_q) state_d = RECV;
            RECV: begin
                if (timeout_hit)                      state_d = IDLE;
                else if (fall && bitcnt_q == 4'd10)   state_d = CHECK;
            end
            CHECK:   state_d = (stop_bad || parity_bad) ? IDLE : DECODE;
            default: state_d = IDLE;
        endcase
    end

    // Results are computed during CHECK so the registered pulses are high in DECODE.
    always_comb begin
        bitcnt_d     = bitcnt_q;
        shreg_d      = shreg_q;
        tmo_d        = '0;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        held_d       = held_q;
        held_code_d  = held_code_q;
        byte_data_d  = byte_data_q;
        key_code_d   = key_code_q;
        key_ext_d    = key_ext_q;
        key1_d       = key1_q;
        key2_d       = key2_q;
        key3_d       = key3_q;
        byte_valid_d = 1'b0;
        key_make_d   = 1'b0;
        key_break_d  = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall && !dat_s2_q) begin
                    bitcnt_d = 4'd1;
                    shreg_d  = '0;
                end
            end
            RECV: begin
                if (fall) begin
                    shreg_d[bitcnt_q] = dat_s2_q;
                    bitcnt_d          = bitcnt_q + 4'd1;
                end else if (timeout_hit) begin
                    frame_err_d = 1'b1;
                    ext_pend_d  = 1'b0;
                    brk_pend_d  = 1'b0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            CHECK: begin
                if (stop_bad || parity_bad) begin
                    frame_err_d  = stop_bad;
                    parity_err_d = !stop_bad;
                    ext_pend_d   = 1'b0;
                    brk_pend_d   = 1'b0;
                end else begin
                    byte_data_d  = rx_byte;
                    byte_valid_d = 1'b1;
                    if (rx_byte == 8'hE0) begin
                        ext_pend_d = 1'b1;
                    end else if (rx_byte == 8'hF0) begin
                        brk_pend_d = 1'b1;
                    end else begin
                        key_code_d = rx_byte;
                        key_ext_d  = ext_pend_q;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                        if (brk_pend_q) begin
                            key_break_d = 1'b1;
                            if (rx_byte == held_code_q) held_d = 1'b0;
                        end else begin
                            key_make_d = 1'b1;
                            // An auto-repeat of the held key leaves the history alone.
                            if (!(held_q && rx_byte == held_code_q)) begin
                                key3_d      = key2_q;
                                key2_d      = key1_q;
                                key1_d      = rx_byte;
                                held_d      = 1'b1;
                                held_code_d = rx_byte;
                            end
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign key_code   = key_code_q;
    assign key_ext    = key_ext_q;
    assign key_make   = key_make_q;
    assign key_break  = key_break_q;
    assign key1       = key1_q;
    assign key2       = key2_q;
    assign key3       = key3_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_ps2_rx_controller.sv
// Bench for ps2_rx_controller: drives PS/2 frames bit by bit and scores every
// output event against an expected queue filled as each frame is sent.
module tb_ps2_rx_controller;
  localparam int W = 46;

  logic       clock50 = 1'b0;
  logic       resetn, ps2_clk, ps2_dat;
  logic [7:0] byte_data, key_code, key1, key2, key3;
  logic       byte_valid, key_ext, key_make, key_break, parity_err, frame_err, busy;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  ps2_rx_controller #(.TIMEOUT_CYCLES(100)) dut (
    .clock50(clock50), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .byte_data(byte_data), .byte_valid(byte_valid), .key_code(key_code),
    .key_ext(key_ext), .key_make(key_make), .key_break(key_break),
    .key1(key1), .key2(key2), .key3(key3), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  // clock / reset
  always #10 clock50 = ~clock50;

  initial begin
    repeat (60000) @(posedge clock50);
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1);
  end

  // scoreboard monitor: every output event pops one expected record
  always @(negedge clock50) begin
    logic [W-1:0] obs, exp_v;
    if (byte_valid || parity_err || frame_err || key_make || key_break) begin
      obs = {parity_err, frame_err, byte_valid, byte_data, key_make, key_break,
             key_code, key_ext, key1, key2, key3};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL event_unexpected: got %h, required no event", obs);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs !== exp_v) begin
          n_err++;
          $display("FAIL event: got %h, required %h", obs, exp_v);
        end
      end
    end
  end

  // driver helpers
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic good_par,
                                           input logic stop);
    logic p;
    p = good_par ? ~^b : ^b;
    return {stop, p, b, 1'b0};
  endfunction

  task automatic push_exp(input logic pe, input logic fe, input logic bv, input logic [7:0] bd,
                          input logic mk, input logic br, input logic [7:0] kc, input logic ke,
                          input logic [7:0] k1, input logic [7:0] k2, input logic [7:0] k3);
    exp_q.push_back({pe, fe, bv, bd, mk, br, kc, ke, k1, k2, k3});
  endtask

  task automatic send_range(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ps2_dat = f[i];
      repeat (10) @(negedge clock50);
      ps2_clk = 1'b0;
      repeat (20) @(negedge clock50);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clock50);
    end
  endtask

  task automatic send_frame(input logic [10:0] f);
    send_range(f, 0, 10);
    repeat (20) @(negedge clock50);
  endtask

  // tests
  task automatic test_reset;
    resetn = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1;
    repeat (3) @(negedge clock50);
    n_cmp++;
    if ({byte_data, byte_valid, key_code, key_ext, key_make, key_break, key1, key2, key3,
         parity_err, frame_err, busy} !== 45'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    resetn = 1'b1;
    repeat (5) @(negedge clock50);
  endtask

  task automatic test_make_latency;
    logic [10:0] f;
    f = mk_frame(8'h1D, 1'b1, 1'b1);
    push_exp(0, 0, 1, 8'h1D, 1, 0, 8'h1D, 0, 8'h1D, 8'h00, 8'h00);
    send_range(f, 0, 9);
    ps2_dat = f[10];
    repeat (10) @(negedge clock50);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clock50);
    n_cmp++;
    if (byte_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early: byte_valid got %b, required 0", byte_valid);
    end
    @(negedge clock50);
    n_cmp++;
    if (byte_valid !== 1'b1) begin
      n_err++;
      $display("FAIL latency_n2: byte_valid got %b, required 1", byte_valid);
    end
    repeat (16) @(negedge clock50);
    ps2_clk = 1'b1;
    repeat (30) @(negedge clock50);
  endtask

  task automatic test_break;
    push_exp(0, 0, 1, 8'hF0, 0, 0, 8'h1D, 0, 8'h1D, 8'h00, 8'h00);
    send_frame(mk_frame(8'hF0, 1'b1, 1'b1));
    push_exp(0, 0, 1, 8'h1D, 0, 1, 8'h1D, 0, 8'h1D, 8'h00, 8'h00);
    send_frame(mk_frame(8'h1D, 1'b1, 1'b1));
  endtask

  task automatic test_history;
    // held was cleared by the break, so this 1D shifts the history
    push_exp(0, 0, 1, 8'h1D, 1, 0, 8'h1D, 0, 8'h1D, 8'h1D, 8'h00);
    send_frame(mk_frame(8'h1D, 1'b1, 1'b1));
    push_exp(0, 0, 1, 8'h1D, 1, 0, 8'h1D, 0, 8'h1D, 8'h1D, 8'h00);
    send_frame(mk_frame(8'h1D, 1'b1, 1'b1));
    push_exp(0, 0, 1, 8'h1B, 1, 0, 8'h1B, 0, 8'h1B, 8'h1D, 8'h1D);
    send_frame(mk_frame(8'h1B, 1'b1, 1'b1));
    push_exp(0, 0, 1, 8'hE0, 0, 0, 8'h1B, 0, 8'h1B, 8'h1D, 8'h1D);
    send_frame(mk_frame(8'hE0, 1'b1, 1'b1));
    push_exp(0, 0, 1, 8'h75, 1, 0, 8'h75, 1, 8'h75, 8'h1B, 8'h1D);
    send_frame(mk_frame(8'h75, 1'b1, 1'b1));
  endtask

  task automatic test_errors;
    push_exp(1, 0, 0, 8'h75, 0, 0, 8'h75, 1, 8'h75, 8'h1B, 8'h1D);
    send_frame(mk_frame(8'h1D, 1'b0, 1'b1));
    push_exp(0, 1, 0, 8'h75, 0, 0, 8'h75, 1, 8'h75, 8'h1B, 8'h1D);
    send_frame(mk_frame(8'h1D, 1'b0, 1'b0));
    // an error after E0 must drop the extended prefix
    push_exp(0, 0, 1, 8'hE0, 0, 0, 8'h75, 1, 8'h75, 8'h1B, 8'h1D);
    send_frame(mk_frame(8'hE0, 1'b1, 1'b1));
    push_exp(1, 0, 0, 8'hE0, 0, 0, 8'h75, 1, 8'h75, 8'h1B, 8'h1D);
    send_frame(mk_frame(8'h42, 1'b0, 1'b1));
    push_exp(0, 0, 1, 8'h5A, 1, 0, 8'h5A, 0, 8'h5A, 8'h75, 8'h1B);
    send_frame(mk_frame(8'h5A, 1'b1, 1'b1));
  endtask

  task automatic test_timeout;
    push_exp(0, 1, 0, 8'h5A, 0, 0, 8'h5A, 0, 8'h5A, 8'h75, 8'h1B);
    send_range(mk_frame(8'h3C, 1'b1, 1'b1), 0, 4);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_busy_before: got %b, required 1", busy);
    end
    repeat (150) @(negedge clock50);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_busy_after: got %b, required 0", busy);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL timeout_frame_err: pending %0d, required 0", exp_q.size());
    end
    push_exp(0, 0, 1, 8'h29, 1, 0, 8'h29, 0, 8'h29, 8'h5A, 8'h75);
    send_frame(mk_frame(8'h29, 1'b1, 1'b1));
  endtask

  task automatic test_reset_midframe;
    logic [10:0] f;
    f = mk_frame(8'hC0, 1'b1, 1'b1);
    send_range(f, 0, 6);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_busy_before: got %b, required 1", busy);
    end
    resetn = 1'b0;
    @(negedge clock50);
    resetn = 1'b1;
    n_cmp++;
    if ({byte_data, byte_valid, key_code, key_ext, key_make, key_break, key1, key2, key3,
         parity_err, frame_err, busy} !== 45'd0) begin
      n_err++;
      $display("FAIL midreset_outputs: got nonzero outputs, required all 0");
    end
    send_range(f, 7, 10);
    repeat (20) @(negedge clock50);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_tail_ignored: busy got %b, required 0", busy);
    end
    push_exp(0, 0, 1, 8'h1C, 1, 0, 8'h1C, 0, 8'h1C, 8'h00, 8'h00);
    send_frame(mk_frame(8'h1C, 1'b1, 1'b1));
  endtask

  initial begin
    test_reset();
    test_make_latency();
    test_break();
    test_history();
    test_errors();
    test_timeout();
    test_reset_midframe();
    repeat (20) @(negedge clock50);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL final_queue: pending %0d, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
